// File: rtl/writeback_64_if.sv
// Purpose: bundles the write-back stage's retire inputs, decode read ports and status outputs.
// Latency: wiring only, no state.
// Backpressure: none; wb_valid is a one-way qualifier and the stage accepts every cycle.
//
// Signals (directions as seen by the slave, i.e. the write-back stage):
//   wb_valid, icode, cnd, rA, rB, valE, valM   in   retiring instruction
//   srcA, srcB                                  in   decode read addresses
//   valA, valB                                  out  decode read data
//   halted, retired                             out  run state / retired count
interface writeback_64_if #(
    parameter int DW    = 64,
    parameter int CNT_W = 32
);
    logic             wb_valid;
    logic [3:0]       icode;
    logic             cnd;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [DW-1:0]    valE;
    logic [DW-1:0]    valM;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [DW-1:0]    valA;
    logic [DW-1:0]    valB;
    logic             halted;
    logic [CNT_W-1:0] retired;

    // Upstream pipeline / testbench side.
    modport master (
        output wb_valid, icode, cnd, rA, rB, valE, valM, srcA, srcB,
        input  valA, valB, halted, retired
    );

    // Write-back stage side.
    modport slave (
        input  wb_valid, icode, cnd, rA, rB, valE, valM, srcA, srcB,
        output valA, valB, halted, retired
    );
endinterface

// File: rtl/writeback_64.sv
// Purpose: SEQ write-back stage + architectural register file, run/halt FSM, retire counter.
// Latency: commit on the clock edge; visible on valA/valB the cycle after; reads are combinational.
// Backpressure: none; every wb_valid in RUN commits, wb_valid in HALT is dropped.
//
// Ports:
//   clk   in   clock, all state on posedge
//   rst   in   synchronous active-high reset
//   bus   slave modport of writeback_64_if (retire inputs, read ports, status)
module writeback_64 #(
    parameter int          DW       = 64,
    parameter int          NREGS    = 15,
    parameter int          CNT_W    = 32,
    parameter logic [DW-1:0] RSP_INIT = '0
) (
    input  logic           clk,
    input  logic           rst,
    writeback_64_if.slave  bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'd4;

    typedef enum logic {RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [3:0]       dst_e, dst_m;
    logic             commit;

    // Destination decode for the E and M write ports.
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        unique case (bus.icode)
            4'd2:                      dst_e = bus.cnd ? bus.rB : RNONE;
            4'd3, 4'd6:                dst_e = bus.rB;
            4'd8, 4'd9, 4'd10, 4'd11:  dst_e = RRSP;
            default:                   dst_e = RNONE;
        endcase
        if (bus.icode == 4'd5 || bus.icode == 4'd11) begin
            dst_m = bus.rA;
        end
    end

    assign commit = (state_q == RUN) && bus.wb_valid;

    // Next state: register file, counter, run/halt.
    always_comb begin
        regs_d    = regs_q;
        retired_d = retired_q;
        state_d   = state_q;
        if (commit) begin
            retired_d = retired_q + 1'b1;
            if (dst_e != RNONE) begin
                regs_d[dst_e] = bus.valE;
            end
            // M port applied second so popq %rsp keeps the loaded value.
            if (dst_m != RNONE) begin
                regs_d[dst_m] = bus.valM;
            end
            if (bus.icode == 4'd0) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
            end
            retired_q <= '0;
            state_q   <= RUN;
        end else begin
            regs_q    <= regs_d;
            retired_q <= retired_d;
            state_q   <= state_d;
        end
    end

    // Read ports see pre-edge contents; no write-through bypass.
    assign bus.valA    = (bus.srcA == RNONE) ? '0 : regs_q[bus.srcA];
    assign bus.valB    = (bus.srcB == RNONE) ? '0 : regs_q[bus.srcB];
    assign bus.halted  = (state_q == HALT);
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_writeback_64.sv
// Purpose: directed bench for writeback_64 (main instance plus a 3-bit counter instance).
// Latency: inputs driven 1ns after posedge, outputs sampled before the next posedge.
// Backpressure: not applicable.
module tb_writeback_64;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    writeback_64_if #(.DW(64), .CNT_W(32)) wb_if ();
    writeback_64_if #(.DW(64), .CNT_W(3))  sm_if ();

    writeback_64 #(.DW(64), .NREGS(15), .CNT_W(32), .RSP_INIT(64'h100)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (wb_if)
    );

    writeback_64 #(.DW(64), .NREGS(15), .CNT_W(3), .RSP_INIT(64'h0)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sm_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
        wb_if.wb_valid = 1'b1;
        wb_if.icode    = ic;
        wb_if.cnd      = c;
        wb_if.rA       = ra;
        wb_if.rB       = rb;
        wb_if.valE     = ve;
        wb_if.valM     = vm;
        tick();
        wb_if.wb_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        wb_if.srcA = a;
        wb_if.srcB = b;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_if.wb_valid = 1'b0; wb_if.icode = 4'd1; wb_if.cnd = 1'b0;
        wb_if.rA = 4'hF; wb_if.rB = 4'hF; wb_if.valE = '0; wb_if.valM = '0;
        wb_if.srcA = 4'h4; wb_if.srcB = 4'h0;
        sm_if.wb_valid = 1'b0; sm_if.icode = 4'd1; sm_if.cnd = 1'b0;
        sm_if.rA = 4'hF; sm_if.rB = 4'hF; sm_if.valE = '0; sm_if.valM = '0;
        sm_if.srcA = 4'hF; sm_if.srcB = 4'hF;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        rd(4'h4, 4'h0);
        check("rst_rsp",     wb_if.valA, 64'h100);
        check("rst_r0",      wb_if.valB, 64'h0);
        check("rst_retired", 64'(wb_if.retired), 64'd0);
        check("rst_halted",  64'(wb_if.halted), 64'd0);

        // irmovq: old value until the edge, new value after
        rd(4'h2, 4'h2);
        wb_if.wb_valid = 1'b1; wb_if.icode = 4'd3; wb_if.rB = 4'd2; wb_if.valE = 64'd777;
        #1;
        check("irmov_pre_edge", wb_if.valA, 64'd0);
        tick();
        wb_if.wb_valid = 1'b0;
        check("irmov_valA",    wb_if.valA, 64'd777);
        check("irmov_valB_eq", wb_if.valB, 64'd777);
        check("irmov_retired", 64'(wb_if.retired), 64'd1);

        // cmovXX not taken, then taken
        rd(4'h5, 4'hF);
        retire(4'd2, 1'b0, 4'hF, 4'd5, 64'd44, 64'd0);
        check("cmov_nt",      wb_if.valA, 64'd0);
        check("srcB_none",    wb_if.valB, 64'd0);
        retire(4'd2, 1'b1, 4'hF, 4'd5, 64'd44, 64'd0);
        check("cmov_t",       wb_if.valA, 64'd44);
        check("cmov_retired", 64'(wb_if.retired), 64'd3);

        // popq %rsp: valM wins over valE on register 4
        rd(4'h4, 4'h3);
        retire(4'd11, 1'b0, 4'd4, 4'hF, 64'h108, 64'h999);
        check("popq_rsp", wb_if.valA, 64'h999);
        retire(4'd11, 1'b0, 4'd3, 4'hF, 64'h110, 64'hABC);
        check("popq_r4",  wb_if.valA, 64'h110);
        check("popq_r3",  wb_if.valB, 64'hABC);

        // Invalid icode: counted, writes nothing
        rd(4'h6, 4'h6);
        retire(4'd12, 1'b1, 4'd6, 4'd6, 64'h55, 64'h66);
        check("inval_r6",      wb_if.valA, 64'h0);
        check("inval_retired", 64'(wb_if.retired), 64'd6);

        // halt, then ignored instruction, then reset (with an instruction lost to rst)
        retire(4'd0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
        check("halt_halted",  64'(wb_if.halted), 64'd1);
        check("halt_retired", 64'(wb_if.retired), 64'd7);
        rd(4'h1, 4'h2);
        retire(4'd3, 1'b0, 4'hF, 4'd1, 64'd5, 64'd0);
        check("halted_r1",      wb_if.valA, 64'd0);
        check("halted_retired", 64'(wb_if.retired), 64'd7);
        check("halted_stays",   64'(wb_if.halted), 64'd1);
        rst = 1'b1;
        retire(4'd3, 1'b0, 4'hF, 4'd1, 64'd9, 64'd0);
        rst = 1'b0;
        rd(4'h1, 4'h2);
        check("rst2_r1",      wb_if.valA, 64'd0);
        check("rst2_r2",      wb_if.valB, 64'd0);
        rd(4'h4, 4'h5);
        check("rst2_rsp",     wb_if.valA, 64'h100);
        check("rst2_r5",      wb_if.valB, 64'd0);
        check("rst2_halted",  64'(wb_if.halted), 64'd0);
        check("rst2_retired", 64'(wb_if.retired), 64'd0);

        // 3-bit counter wraps after 8 nops; idle cycles do not count
        sm_if.icode = 4'd1;
        for (int i = 0; i < 8; i++) begin
            sm_if.wb_valid = 1'b1;
            tick();
            sm_if.wb_valid = 1'b0;
            if (i == 2) begin
                check("wrap_cnt3", 64'(sm_if.retired), 64'd3);
                tick();
                check("wrap_idle", 64'(sm_if.retired), 64'd3);
            end
            if (i == 6) check("wrap_cnt7", 64'(sm_if.retired), 64'd7);
        end
        check("wrap_zero",   64'(sm_if.retired), 64'd0);
        check("wrap_halted", 64'(sm_if.halted), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
